episode_controller: RTL
=======================

EPISODE_CONTROLLER -- requirements
Module: episode_controller

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- GRID_W, 5, grid side length; states are numbered 1..GRID_W*GRID_W, row-major, state 1 at top-left.
- START_STATE, 1, state loaded at episode start.
- GOAL_STATE, 25, terminal state.
- MAX_STEPS, 40, step limit per episode.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; every register updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- start, input, 1, starts an episode; acted on only in IDLE.
- abort, input, 1, ends the episode early; acted on only in ACT or UPD.
- action_valid, input, 1, the policy presents an action.
- new_action, input, 4, 0=right, 1=up, 2=left, 3=down, others=stay.
- action_ready, output, 1, the controller accepts an action.
- upd_valid, output, 1, a transition record is valid for the learner.
- upd_ready, input, 1, the learner accepts the record.
- upd_state, output, 6, state before the move.
- upd_action, output, 4, action that was taken.
- upd_next, output, 6, state after the move.
- upd_reward, output, 8, signed reward.
- current_state, output, 6, agent position.
- step_count, output, 6, steps completed in this episode.
- episode_count, output, 16, episodes completed.
- episode_done, output, 1, one-cycle pulse at episode end.
- busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-003 The FSM SHALL have the states IDLE, ACT, UPD and DONE.
REQ-004 In IDLE, start=1 SHALL load current_state=START_STATE and step_count=0, with ACT entered on the next cycle.
REQ-005 action_ready SHALL be 1 exactly when the FSM is in ACT; the handshake completes when action_valid and action_ready are both 1 in the same cycle.
REQ-006 When the action handshake completes, the block SHALL latch upd_state=current_state, upd_action=new_action, upd_next and upd_reward, and enter UPD; upd_valid SHALL rise on the next cycle.
REQ-007 The next-state rules SHALL be as follows:
- right: allowed if state mod GRID_W != 0, giving state+1.
- up: allowed if state > GRID_W, giving state-GRID_W.
- left: allowed if state mod GRID_W != 1, giving state-1.
- down: allowed if state <= GRID_W*(GRID_W-1), giving state+GRID_W.
- a disallowed move, or any action code 4..15, SHALL leave the state unchanged.
REQ-008 upd_reward SHALL be +100 if upd_next==GOAL_STATE, otherwise -10 if the move was blocked, otherwise -1; action codes 4..15 SHALL count as blocked.
REQ-009 In UPD, upd_valid SHALL stay 1 and all upd_* fields SHALL hold stable until upd_ready=1.
REQ-010 On the upd handshake, the block SHALL set current_state<=upd_next and step_count<=step_count+1.
REQ-011 After the upd handshake, the FSM SHALL go to DONE if upd_next==GOAL_STATE or the new step_count==MAX_STEPS, and to ACT otherwise.
REQ-012 In DONE, the block SHALL assert episode_done for one cycle, increment episode_count (wrapping 0xFFFF->0), and return to IDLE.
REQ-013 abort=1 in ACT or UPD SHALL return the FSM to IDLE on the next cycle.
- It SHALL drop upd_valid.
- It SHALL NOT pulse episode_done or increment episode_count.
- It SHALL take priority over a handshake in the same cycle.
REQ-014 start outside IDLE and abort in IDLE or DONE SHALL be ignored.
REQ-015 step_count and current_state SHALL hold their final values in IDLE until the next start.

Reset
REQ-016 rst=1 SHALL force the following values, overriding any other input:
- FSM to IDLE;
- current_state=START_STATE;
- step_count=0, episode_count=0;
- upd_state=0, upd_action=0, upd_next=0, upd_reward=0;
- upd_valid=0, action_ready=0, episode_done=0, busy=0.
REQ-017 Reset mid-episode SHALL discard any pending record without an upd handshake.

Structure
REQ-018 The action encodings, the reward constants (+100, -10, -1) and the FSM state enumeration SHALL live in a shared package, rl_pkg.
REQ-019 The next-state and blocked computation SHALL be a combinational sub-module, grid_step, with inputs new_action and current_state and outputs next_state and blocked.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- start; actions right x4, then down x4, upd_ready always 1 -> states 2,3,4,5,10,15,20,25; last reward +100; episode_done pulses once; step_count=8; episode_count=1.
- From state 1, actions up then left -> upd_next=1 both times, reward -10 both times, step_count=2.
- From state 1, action 4'b0111 -> upd_next=1, reward -10.
- With upd_ready held 0 for 5 cycles -> upd_* stay stable and current_state does not change; it updates on the cycle after upd_ready=1.
- Alternate right/left from state 1 for MAX_STEPS=40 steps -> DONE at step_count=40 with current_state=1.
- abort asserted together with upd_ready in UPD -> IDLE; episode_count unchanged; no episode_done pulse.

Source files
------------

// File: rtl/rl_pkg.sv
// Shared definitions for the grid-world episode controller.
//   - Action encodings presented by the policy on new_action.
//   - Reward constants reported on upd_reward.
//   - Controller FSM state enumeration.
package rl_pkg;

    // Action codes; every other 4-bit code means "stay".
    localparam logic [3:0] ACT_RIGHT = 4'd0;
    localparam logic [3:0] ACT_UP    = 4'd1;
    localparam logic [3:0] ACT_LEFT  = 4'd2;
    localparam logic [3:0] ACT_DOWN  = 4'd3;

    // Rewards (8-bit signed).
    localparam logic signed [7:0] REWARD_GOAL    = 8'sd100;
    localparam logic signed [7:0] REWARD_BLOCKED = -8'sd10;
    localparam logic signed [7:0] REWARD_STEP    = -8'sd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACT  = 2'd1,
        ST_UPD  = 2'd2,
        ST_DONE = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/grid_step.sv
// Combinational grid-world move.
// Given the agent position (1..GRID_W*GRID_W, row-major, 1 at top-left)
// and an action code, produce the resulting position and whether the
// move was blocked (wall hit or a non-move action code).
// Ports:
//   new_action    [3:0] action code (see rl_pkg)
//   current_state [5:0] position before the move
//   next_state    [5:0] position after the move
//   blocked             1 when the position did not change by a legal move
module grid_step
    import rl_pkg::*;
#(
    parameter int GRID_W = 5
) (
    input  logic [3:0] new_action,
    input  logic [5:0] current_state,
    output logic [5:0] next_state,
    output logic       blocked
);

    localparam logic [5:0] GW       = 6'(GRID_W);
    localparam logic [5:0] LAST_ROW = 6'(GRID_W * (GRID_W - 1));

    // Column position: 0 means right-most column, 1 means left-most.
    logic [5:0] col;
    assign col = current_state % GW;

    always_comb begin
        next_state = current_state;
        blocked    = 1'b1;
        case (new_action)
            ACT_RIGHT: begin
                if (col != 6'd0) begin
                    next_state = current_state + 6'd1;
                    blocked    = 1'b0;
                end
            end
            ACT_UP: begin
                if (current_state > GW) begin
                    next_state = current_state - GW;
                    blocked    = 1'b0;
                end
            end
            ACT_LEFT: begin
                if (col != 6'd1) begin
                    next_state = current_state - 6'd1;
                    blocked    = 1'b0;
                end
            end
            ACT_DOWN: begin
                if (current_state <= LAST_ROW) begin
                    next_state = current_state + GW;
                    blocked    = 1'b0;
                end
            end
            default: begin
                next_state = current_state;
                blocked    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/episode_controller.sv
// Episode controller for a tabular RL agent on a GRID_W x GRID_W grid.
// Accepts actions from a policy, computes the transition record
// (state, action, next, reward) and hands it to a learner with a
// valid/ready handshake; tracks position, step count and episode count.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin an episode (IDLE only)
//   abort                    end the episode early (ACT/UPD only)
//   action_valid/new_action  policy action, accepted when action_ready
//   action_ready             high in ACT
//   upd_valid/upd_ready      transition record handshake
//   upd_state/upd_action/upd_next/upd_reward  transition record
//   current_state            agent position
//   step_count               steps completed this episode
//   episode_count            episodes completed (wraps)
//   episode_done             one-cycle pulse at episode end
//   busy                     FSM not in IDLE
module episode_controller
    import rl_pkg::*;
#(
    parameter int GRID_W      = 5,
    parameter int START_STATE = 1,
    parameter int GOAL_STATE  = 25,
    parameter int MAX_STEPS   = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        action_valid,
    input  logic [3:0]  new_action,
    output logic        action_ready,
    output logic        upd_valid,
    input  logic        upd_ready,
    output logic [5:0]  upd_state,
    output logic [3:0]  upd_action,
    output logic [5:0]  upd_next,
    output logic [7:0]  upd_reward,
    output logic [5:0]  current_state,
    output logic [5:0]  step_count,
    output logic [15:0] episode_count,
    output logic        episode_done,
    output logic        busy
);

    localparam logic [5:0] START_C = 6'(START_STATE);
    localparam logic [5:0] GOAL_C  = 6'(GOAL_STATE);
    localparam logic [5:0] MAX_C   = 6'(MAX_STEPS);

    ctrl_state_t state_q, state_d;

    logic [5:0]        step_next;
    logic              blocked;
    logic [5:0]        step_inc;
    logic signed [7:0] reward_d;
    logic              act_hs;
    logic              upd_hs;

    grid_step #(
        .GRID_W (GRID_W)
    ) u_grid_step (
        .new_action    (new_action),
        .current_state (current_state),
        .next_state    (step_next),
        .blocked       (blocked)
    );

    assign step_inc = step_count + 6'd1;

    // Abort wins over either handshake in the same cycle.
    assign act_hs = (state_q == ST_ACT) && action_valid && !abort;
    assign upd_hs = (state_q == ST_UPD) && upd_ready && !abort;

    // Goal reward takes precedence over the blocked penalty.
    always_comb begin
        if (step_next == GOAL_C)
            reward_d = REWARD_GOAL;
        else if (blocked)
            reward_d = REWARD_BLOCKED;
        else
            reward_d = REWARD_STEP;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start)
                    state_d = ST_ACT;
            end
            ST_ACT: begin
                if (abort)
                    state_d = ST_IDLE;
                else if (action_valid)
                    state_d = ST_UPD;
            end
            ST_UPD: begin
                if (abort)
                    state_d = ST_IDLE;
                else if (upd_ready) begin
                    if (upd_next == GOAL_C || step_inc == MAX_C)
                        state_d = ST_DONE;
                    else
                        state_d = ST_ACT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            current_state <= START_C;
            step_count    <= 6'd0;
            episode_count <= 16'd0;
            upd_state     <= 6'd0;
            upd_action    <= 4'd0;
            upd_next      <= 6'd0;
            upd_reward    <= 8'd0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                current_state <= START_C;
                step_count    <= 6'd0;
            end
            if (act_hs) begin
                upd_state  <= current_state;
                upd_action <= new_action;
                upd_next   <= step_next;
                upd_reward <= reward_d;
            end
            if (upd_hs) begin
                current_state <= upd_next;
                step_count    <= step_inc;
            end
            if (state_q == ST_DONE)
                episode_count <= episode_count + 16'd1;
        end
    end

    // Status outputs decode straight from the state register; DONE lasts
    // exactly one cycle so episode_done is a single pulse.
    assign action_ready = (state_q == ST_ACT);
    assign upd_valid    = (state_q == ST_UPD);
    assign episode_done = (state_q == ST_DONE);
    assign busy         = (state_q != ST_IDLE);

endmodule
